// File: rtl/mem_responder.sv
// Memory-side responder: sized reads/writes into a word-organised synchronous RAM,
// with word-crossing accesses split into two RAM operations.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        rd_req_i,
  input  logic [31:0] rd_addr_i,
  input  logic [1:0]  rd_size_i,
  input  logic        wr_enable_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [1:0]  wr_size_i,
  output logic        ready_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        wr_done_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_B, RD_PEND} state_t;

  typedef struct packed {
    logic          err;
    logic          split;
    logic [1:0]    lane;
    logic [2:0]    nbytes;
    logic [AW-1:0] word;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] addr, input logic [1:0] size);
    dec_t        d;
    logic [31:0] off;
    logic [32:0] last;
    off      = addr - BASE_ADDR;
    d.nbytes = (size == 2'd0) ? 3'd1 : (size == 2'd1) ? 3'd2 : 3'd4;
    d.lane   = off[1:0];
    d.word   = off[AW+1:2];
    d.split  = ({1'b0, d.lane} + d.nbytes) > 3'd4;
    last     = {1'b0, off} + {30'd0, d.nbytes};
    d.err    = (addr < BASE_ADDR) || (last > LIMIT);
    return d;
  endfunction

  function automatic logic [31:0] extract(input logic [63:0] w, input logic [1:0] lane,
                                          input logic [2:0] nbytes);
    logic [63:0] s;
    s = w >> {lane, 3'b000};
    case (nbytes)
      3'd1:    return {24'd0, s[7:0]};
      3'd2:    return {16'd0, s[15:0]};
      default: return s[31:0];
    endcase
  endfunction

  state_t        state_q, state_d;
  dec_t          rd_dec, wr_dec;
  logic          accept_rd, accept_wr, wr_go;
  logic [63:0]   wr_shift;
  logic [3:0]    be_base;
  logic [7:0]    wr_be8;

  logic [1:0]    rq_lane;
  logic [2:0]    rq_nbytes;
  logic [AW-1:0] rq_word;
  logic          rq_split, rq_err, rq_pend;
  logic [AW-1:0] wb_word;
  logic [3:0]    wb_be;
  logic [31:0]   wb_data;
  logic [31:0]   ram_q, a_q, rd_hold, rd_now;
  logic          wr_done_q, err_q;

  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   mem [DEPTH_WORDS];

  assign rd_dec    = decode(rd_addr_i, rd_size_i);
  assign wr_dec    = decode(wr_addr_i, wr_size_i);
  assign accept_wr = (state_q == IDLE) && wr_enable_i;
  assign accept_rd = (state_q == IDLE) && rd_req_i;
  assign wr_go     = accept_wr && !wr_dec.err;
  assign be_base   = (wr_dec.nbytes == 3'd1) ? 4'b0001 :
                     (wr_dec.nbytes == 3'd2) ? 4'b0011 : 4'b1111;
  assign wr_be8    = {4'd0, be_base} << wr_dec.lane;
  assign wr_shift  = {32'd0, wr_data_i} << {wr_dec.lane, 3'b000};

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // A write always goes first; a read accepted alongside it waits in RD_PEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_wr)
          state_d = (wr_go && wr_dec.split) ? WR_B : (accept_rd ? RD_PEND : IDLE);
        else if (accept_rd && !rd_dec.err)
          state_d = RD_A;
      end
      WR_B:    state_d = rq_pend ? RD_PEND : IDLE;
      RD_PEND: state_d = rq_err ? IDLE : RD_A;
      RD_A:    state_d = rq_split ? RD_B : IDLE;
      RD_B:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o    = (state_q == IDLE);
    rd_valid_o = ((state_q == RD_A) && !rq_split) || (state_q == RD_B);
    rd_now     = (state_q == RD_B) ? extract({ram_q, a_q}, rq_lane, rq_nbytes)
                                   : extract({32'd0, ram_q}, rq_lane, rq_nbytes);
    rd_data_o  = rd_valid_o ? rd_now : rd_hold;
    wr_done_o  = wr_done_q;
    err_o      = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rq_pend   <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      rd_hold   <= 32'd0;
    end else begin
      wr_done_q <= (wr_go && !wr_dec.split) || (state_q == WR_B);
      err_q     <= (accept_wr && wr_dec.err) ||
                   (accept_rd && !accept_wr && rd_dec.err) ||
                   ((state_q == RD_PEND) && rq_err);
      if (accept_rd)                rq_pend <= accept_wr;
      else if (state_q == RD_PEND)  rq_pend <= 1'b0;
      if (rd_valid_o)               rd_hold <= rd_now;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_rd) begin
      rq_lane   <= rd_dec.lane;
      rq_nbytes <= rd_dec.nbytes;
      rq_word   <= rd_dec.word;
      rq_split  <= rd_dec.split;
      rq_err    <= rd_dec.err;
    end
    if (wr_go) begin
      wb_word <= wr_dec.word + AW'(1);
      wb_be   <= wr_be8[7:4];
      wb_data <= wr_shift[63:32];
    end
    if (state_q == RD_A) a_q <= ram_q;
  end

  always_comb begin
    ram_we    = wr_go || (state_q == WR_B);
    ram_waddr = (state_q == WR_B) ? wb_word : wr_dec.word;
    ram_be    = (state_q == WR_B) ? wb_be : wr_be8[3:0];
    ram_wdata = (state_q == WR_B) ? wb_data : wr_shift[31:0];
    ram_re    = 1'b0;
    ram_raddr = rq_word;
    case (state_q)
      IDLE: begin
        ram_re    = accept_rd && !accept_wr && !rd_dec.err;
        ram_raddr = rd_dec.word;
      end
      RD_PEND: ram_re = !rq_err;
      RD_A: begin
        ram_re    = rq_split;
        ram_raddr = rq_word + AW'(1);
      end
      default: ram_re = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_re) ram_q <= mem[ram_raddr];
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed vector table, reset-in-split sequence and
// randomized traffic checked against a byte-level memory model.
module tb_mem_responder;

  localparam int unsigned DEPTH = 16384;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          WIN   = 6;

  logic        clk;
  logic        reset_ni;
  logic        rd_req_i, wr_enable_i;
  logic [31:0] rd_addr_i, wr_addr_i, wr_data_i;
  logic [1:0]  rd_size_i, wr_size_i;
  logic        ready_o, rd_valid_o, wr_done_o, err_o;
  logic [31:0] rd_data_o;

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .INIT_FILE("")) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_size_i(rd_size_i),
    .wr_enable_i(wr_enable_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_size_i(wr_size_i), .ready_o(ready_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .wr_done_o(wr_done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] raddr;
    logic [1:0]  rsize;
    bit          wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  wsize;
    logic [31:0] exp_data;
    logic [31:0] exp_mask;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model_mem [int];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp, input logic [31:0] mask);
    n_tests++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h)", name, act, exp, mask);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic longint m_off(input logic [31:0] a);
    return longint'({32'd0, a}) - longint'({32'd0, BASE});
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] s);
    return (m_off(a) < 0) || (m_off(a) + nb(s) > longint'(DEPTH) * 4);
  endfunction

  function automatic bit m_split(input logic [31:0] a, input logic [1:0] s);
    return (int'(m_off(a) % 4) + nb(s)) > 4;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    for (int i = 0; i < nb(s); i++) model_mem[int'(m_off(a)) + i] = d[8*i +: 8];
  endtask

  // Known bytes compare exactly; bytes above the access size must read as zero.
  task automatic m_read(input logic [31:0] a, input logic [1:0] s,
                        output logic [31:0] exp, output logic [31:0] mask);
    exp  = '0;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= nb(s)) mask[8*i +: 8] = 8'hFF;
      else if (model_mem.exists(int'(m_off(a)) + i)) begin
        exp[8*i +: 8]  = model_mem[int'(m_off(a)) + i];
        mask[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  function automatic vec_t mk(input bit rd, input logic [31:0] ra, input logic [1:0] rs,
                              input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [1:0] ws, input logic [31:0] ed, input logic [31:0] em);
    vec_t v;
    v.rd = rd; v.raddr = ra; v.rsize = rs;
    v.wr = wr; v.waddr = wa; v.wdata = wd; v.wsize = ws;
    v.exp_data = ed; v.exp_mask = em;
    return v;
  endfunction

  task automatic applyStimulus(input string tag, input vec_t v);
    int guard;
    bit werr, wsplit, rerr, rsplit;
    int lw, rd_evt, exp_wr_cyc, exp_rd_cyc, exp_busy;
    logic [31:0] exp_err_mask, m_data, m_mask;
    int got_wr_cyc, got_rd_cyc, got_wr_cnt, got_rd_cnt, got_busy;
    logic [31:0] got_err_mask, got_data;

    guard = 0;
    while (!ready_o && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput({tag, " ready_before_req"}, {31'd0, ready_o}, 32'd1, 32'd1);

    werr   = v.wr && m_err(v.waddr, v.wsize);
    wsplit = v.wr && !werr && m_split(v.waddr, v.wsize);
    rerr   = v.rd && m_err(v.raddr, v.rsize);
    rsplit = v.rd && !rerr && m_split(v.raddr, v.rsize);
    if (v.wr && !werr) m_write(v.waddr, v.wdata, v.wsize);
    m_data = '0;
    m_mask = '0;
    if (v.rd && !rerr) m_read(v.raddr, v.rsize, m_data, m_mask);

    lw           = v.wr ? (wsplit ? 2 : 1) : 0;
    rd_evt       = v.rd ? ((v.wr ? lw + 1 : 1) + (rsplit ? 1 : 0)) : 0;
    exp_wr_cyc   = (v.wr && !werr) ? lw : 0;
    exp_rd_cyc   = (v.rd && !rerr) ? rd_evt : 0;
    exp_err_mask = (werr ? (32'd1 << lw) : 32'd0) | (rerr ? (32'd1 << rd_evt) : 32'd0);
    if (v.rd)  exp_busy = rerr ? rd_evt - 1 : rd_evt;
    else       exp_busy = wsplit ? 1 : 0;

    rd_req_i    = v.rd;
    rd_addr_i   = v.raddr;
    rd_size_i   = v.rsize;
    wr_enable_i = v.wr;
    wr_addr_i   = v.waddr;
    wr_data_i   = v.wdata;
    wr_size_i   = v.wsize;
    tick();
    rd_req_i    = 1'b0;
    wr_enable_i = 1'b0;

    got_wr_cyc = 0; got_rd_cyc = 0; got_wr_cnt = 0; got_rd_cnt = 0; got_busy = 0;
    got_err_mask = '0; got_data = '0;
    for (int c = 1; c <= WIN; c++) begin
      if (wr_done_o) begin
        got_wr_cnt++;
        if (got_wr_cyc == 0) got_wr_cyc = c;
      end
      if (rd_valid_o) begin
        got_rd_cnt++;
        if (got_rd_cyc == 0) begin
          got_rd_cyc = c;
          got_data   = rd_data_o;
        end
      end
      if (err_o)    got_err_mask[c] = 1'b1;
      if (!ready_o) got_busy++;
      tick();
    end

    checkOutput({tag, " wr_done_cycle"}, 32'(got_wr_cyc), 32'(exp_wr_cyc), '1);
    checkOutput({tag, " wr_done_count"}, 32'(got_wr_cnt), (v.wr && !werr) ? 32'd1 : 32'd0, '1);
    checkOutput({tag, " rd_valid_cycle"}, 32'(got_rd_cyc), 32'(exp_rd_cyc), '1);
    checkOutput({tag, " rd_valid_count"}, 32'(got_rd_cnt), (v.rd && !rerr) ? 32'd1 : 32'd0, '1);
    checkOutput({tag, " err_cycles"}, got_err_mask, exp_err_mask, '1);
    checkOutput({tag, " busy_cycles"}, 32'(got_busy), 32'(exp_busy), '1);
    if (v.rd && !rerr && m_mask != 32'd0)
      checkOutput({tag, " rd_data_model"}, got_data, m_data, m_mask);
    if (v.exp_mask != 32'd0)
      checkOutput({tag, " rd_data_table"}, got_data, v.exp_data, v.exp_mask);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [31:0] last_w;

    reset_ni = 1'b0; rd_req_i = 1'b0; wr_enable_i = 1'b0;
    rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0; rd_size_i = '0; wr_size_i = '0;
    tick(); tick();
    reset_ni = 1'b1;
    checkOutput("reset ready_o",    {31'd0, ready_o},    32'd1, '1);
    checkOutput("reset rd_valid_o", {31'd0, rd_valid_o}, 32'd0, '1);
    checkOutput("reset wr_done_o",  {31'd0, wr_done_o},  32'd0, '1);
    checkOutput("reset err_o",      {31'd0, err_o},      32'd0, '1);
    checkOutput("reset rd_data_o",  rd_data_o,           32'd0, '1);

    last_w = BASE + DEPTH * 4 - 4;
    vecs.push_back(mk(0, 0, 0, 1, 32'h0001_0000, 32'h1122_3344, 2, 0, 0));
    vecs.push_back(mk(1, 32'h0001_0000, 2, 0, 0, 0, 0, 32'h1122_3344, '1));
    vecs.push_back(mk(1, 32'h0001_0003, 0, 0, 0, 0, 0, 32'h0000_0011, '1));
    vecs.push_back(mk(1, 32'h0001_0002, 1, 0, 0, 0, 0, 32'h0000_1122, '1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0001_0001, 32'hFFFF_FFAA, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0001_0000, 2, 0, 0, 0, 0, 32'h1122_AA44, '1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0001_0006, 32'hDEAD_BEEF, 2, 0, 0));
    vecs.push_back(mk(1, 32'h0001_0006, 2, 0, 0, 0, 0, 32'hDEAD_BEEF, '1));
    vecs.push_back(mk(1, 32'h0001_0004, 2, 0, 0, 0, 0, 32'hBEEF_0000, 32'hFFFF_0000));
    vecs.push_back(mk(1, 32'h0001_0008, 2, 0, 0, 0, 0, 32'h0000_DEAD, 32'h0000_FFFF));
    vecs.push_back(mk(1, 32'h0001_0010, 2, 1, 32'h0001_0010, 32'h5555_AAAA, 2, 32'h5555_AAAA, '1));
    vecs.push_back(mk(1, 32'h0000_FFFC, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, last_w, 32'h0BAD_F00D, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, last_w + 2, 32'h1234_5678, 2, 0, 0));
    vecs.push_back(mk(1, last_w, 2, 0, 0, 0, 0, 32'h0BAD_F00D, '1));
    vecs.push_back(mk(1, last_w + 2, 1, 0, 0, 0, 0, 32'h0000_0BAD, '1));
    vecs.push_back(mk(1, last_w + 3, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0001_0023, 1, 1, 32'h0001_0021, 32'hCAFE_F00D, 2, 32'h0000_CAFE, '1));
    vecs.push_back(mk(1, 32'h0001_0000, 3, 0, 0, 0, 0, 32'h1122_AA44, '1));

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Reset while the second half of a split read is on the outputs.
    rd_req_i = 1'b1; rd_addr_i = 32'h0001_0006; rd_size_i = 2'd2;
    tick();
    rd_req_i = 1'b0;
    tick();
    checkOutput("rd_b pre-reset rd_valid_o", {31'd0, rd_valid_o}, 32'd1, '1);
    reset_ni = 1'b0;
    tick();
    reset_ni = 1'b1;
    checkOutput("rd_b reset ready_o",    {31'd0, ready_o},    32'd1, '1);
    checkOutput("rd_b reset rd_valid_o", {31'd0, rd_valid_o}, 32'd0, '1);
    checkOutput("rd_b reset rd_data_o",  rd_data_o,           32'd0, '1);
    applyStimulus("post_reset_read", mk(1, 32'h0001_0000, 2, 0, 0, 0, 0, 32'h1122_AA44, '1));

    for (int i = 0; i < 150; i++) begin
      int kind;
      logic [31:0] ra, wa;
      kind = int'($urandom_range(0, 2));
      ra = BASE + $urandom_range(0, 60);
      wa = BASE + $urandom_range(0, 60);
      if ($urandom_range(0, 9) == 0) ra = ($urandom_range(0, 1) == 0) ? BASE - $urandom_range(1, 8)
                                                                     : last_w + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) wa = ($urandom_range(0, 1) == 0) ? BASE - $urandom_range(1, 8)
                                                                     : last_w + $urandom_range(0, 3);
      v = mk(kind != 1, ra, 2'($urandom_range(0, 3)), kind != 0, wa, $urandom,
             2'($urandom_range(0, 3)), 0, 0);
      applyStimulus($sformatf("rand%0d", i), v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
